// File: rtl/arb_mux_reg.sv
// Registered N-channel valid/ready multiplexer with round-robin or fixed-priority
// arbitration, a manual-select override and one output register stage.
module arb_mux_reg #(
   parameter int WIDTH    = 20,
   parameter int CHANNELS = 4,
   parameter int RR       = 1,
   parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      force_en,
   input  logic [3:0]                force_sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int unsigned CH = CHANNELS;

   logic                      load;
   logic                      gnt_any;
   logic [SEL_W-1:0]          gnt;
   logic [SEL_W-1:0]          ptr;
   logic [SEL_W-1:0]          ptr_nxt;
   logic [WIDTH-1:0]          sel_data;
   logic [CHANNELS*WIDTH-1:0] data_sh;

   assign load = !out_valid || out_ready;

   // Channel bits are picked by shifting rather than indexing so the scan
   // works for any CHANNELS, including non-powers of two.
   always_comb begin
      logic [CHANNELS-1:0] vsh;
      int unsigned         idx;
      gnt_any = 1'b0;
      gnt     = '0;
      vsh     = '0;
      idx     = 0;
      if (force_en) begin
         vsh = in_valid >> force_sel;
         if (32'(force_sel) < CH && vsh[0]) begin
            gnt_any = 1'b1;
            gnt     = SEL_W'(force_sel);
         end
      end else if (RR != 0) begin
         for (int unsigned k = 0; k < CH; k++) begin
            idx = (32'(ptr) + k) % CH;
            vsh = in_valid >> idx;
            if (!gnt_any && vsh[0]) begin
               gnt_any = 1'b1;
               gnt     = SEL_W'(idx);
            end
         end
      end else begin
         for (int unsigned i = 0; i < CH; i++) begin
            vsh = in_valid >> i;
            if (!gnt_any && vsh[0]) begin
               gnt_any = 1'b1;
               gnt     = SEL_W'(i);
            end
         end
      end
   end

   always_comb begin
      data_sh  = in_data >> (32'(gnt) * WIDTH);
      sel_data = data_sh[WIDTH-1:0];
      ptr_nxt  = (32'(gnt) == CH - 1) ? '0 : gnt + SEL_W'(1);
      in_ready = '0;
      if (!rst && load && gnt_any)
         in_ready = {{(CHANNELS-1){1'b0}}, 1'b1} << gnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (gnt_any) begin
            out_data  <= sel_data;
            out_sel   <= gnt;
            out_valid <= 1'b1;
            ptr       <= ptr_nxt;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed self-checking bench for arb_mux_reg: a 4-channel round-robin
// instance and a 3-channel, 8-bit fixed-priority instance.
module tb_arb_mux_reg;

   logic        clk = 1'b0;
   logic        rst;
   int          checks = 0;
   int          errors = 0;

   logic [79:0] in_data;
   logic [3:0]  in_valid, in_ready;
   logic        force_en;
   logic [3:0]  force_sel;
   logic [19:0] out_data;
   logic [1:0]  out_sel;
   logic        out_valid, out_ready;

   logic [23:0] f_in_data;
   logic [2:0]  f_in_valid, f_in_ready;
   logic        f_force_en;
   logic [3:0]  f_force_sel;
   logic [7:0]  f_out_data;
   logic [1:0]  f_out_sel;
   logic        f_out_valid, f_out_ready;

   arb_mux_reg #(.WIDTH(20), .CHANNELS(4), .RR(1)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .force_en(force_en), .force_sel(force_sel),
      .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   arb_mux_reg #(.WIDTH(8), .CHANNELS(3), .RR(0)) dut_fp (
      .clk(clk), .rst(rst), .in_data(f_in_data), .in_valid(f_in_valid),
      .in_ready(f_in_ready), .force_en(f_force_en), .force_sel(f_force_sel),
      .out_data(f_out_data), .out_sel(f_out_sel), .out_valid(f_out_valid),
      .out_ready(f_out_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      force_en = 1'b0; force_sel = 4'd0;
      for (int i = 0; i < 4; i++) in_data[i*20 +: 20] = 20'h10000 + 20'(i);
      f_in_data = 24'h332211; f_in_valid = 3'b000; f_force_en = 1'b0;
      f_force_sel = 4'd0; f_out_ready = 1'b1;
      #2;
      checks++;
      if ({out_valid, out_data, out_sel} !== 23'd0) begin
         errors++; $display("FAIL reset_out: got v=%b d=%h s=%0d, expected all 0", out_valid, out_data, out_sel);
      end
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_ready: got %b, expected 0000", in_ready);
      end
      tick(); tick();
      rst = 1'b0;
      in_valid = 4'b0010; in_data[20 +: 20] = 20'hABCDE;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
         errors++; $display("FAIL load_ch1_ready: got %b, expected 0010", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 20'hABCDE || out_sel !== 2'd1) begin
         errors++; $display("FAIL load_ch1_out: got v=%b d=%h s=%0d, expected 1 abcde 1", out_valid, out_data, out_sel);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_data, out_sel} !== 23'd0 || in_ready !== 4'b0000) begin
         errors++; $display("FAIL async_reset: got v=%b d=%h s=%0d r=%b, expected all 0", out_valid, out_data, out_sel, in_ready);
      end
      tick();
      rst = 1'b0;
      in_valid = 4'b1111; in_data[20 +: 20] = 20'h10001;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++; $display("FAIL ptr_after_reset: got %b, expected 0001", in_ready);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] e;
      in_valid = 4'b1111; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         e = 4'(1 << (c % 4));
         checks++;
         if (in_ready !== e) begin
            errors++; $display("FAIL rr_ready[%0d]: got %b, expected %b", c, in_ready, e);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_sel !== 2'(c % 4) || out_data !== 20'h10000 + 20'(c % 4)) begin
            errors++; $display("FAIL rr_out[%0d]: got v=%b s=%0d d=%h, expected 1 %0d %h", c, out_valid, out_sel, out_data, c % 4, 20'h10000 + 20'(c % 4));
         end
      end
   endtask

   task automatic test_back_to_back();
      // ptr is 2 here: load ch2, then stall the consumer
      tick();
      checks++;
      if (out_sel !== 2'd2 || out_data !== 20'h10002) begin
         errors++; $display("FAIL bp_load_ch2: got s=%0d d=%h, expected 2 10002", out_sel, out_data);
      end
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_ready[%0d]: got %b, expected 0000", c, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 20'h10002) begin
            errors++; $display("FAIL bp_hold[%0d]: got v=%b s=%0d d=%h, expected 1 2 10002", c, out_valid, out_sel, out_data);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin
         errors++; $display("FAIL bp_release_ready: got %b, expected 1000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 20'h10003) begin
         errors++; $display("FAIL bp_no_bubble: got v=%b s=%0d d=%h, expected 1 3 10003", out_valid, out_sel, out_data);
      end
   endtask

   task automatic test_wrap();
      in_valid = 4'b0100;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         errors++; $display("FAIL wrap_ch2_ready: got %b, expected 0100", in_ready);
      end
      tick();
      checks++;
      if (out_sel !== 2'd2) begin
         errors++; $display("FAIL wrap_ch2_sel: got %0d, expected 2", out_sel);
      end
      in_valid = 4'b0001;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++; $display("FAIL wrap_ch0_ready: got %b, expected 0001", in_ready);
      end
      tick();
      checks++;
      if (out_sel !== 2'd0 || out_data !== 20'h10000) begin
         errors++; $display("FAIL wrap_ch0_out: got s=%0d d=%h, expected 0 10000", out_sel, out_data);
      end
      in_valid = 4'b1111;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
         errors++; $display("FAIL wrap_ptr1: got %b, expected 0010", in_ready);
      end
   endtask

   task automatic test_force();
      force_en = 1'b1; force_sel = 4'd2; in_valid = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0100) begin
            errors++; $display("FAIL force_ready[%0d]: got %b, expected 0100", c, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 20'h10002) begin
            errors++; $display("FAIL force_out[%0d]: got v=%b s=%0d d=%h, expected 1 2 10002", c, out_valid, out_sel, out_data);
         end
      end
      in_valid = 4'b1011;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++; $display("FAIL force_invalid_ready: got %b, expected 0000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_sel !== 2'd2 || out_data !== 20'h10002) begin
         errors++; $display("FAIL force_drain: got v=%b s=%0d d=%h, expected 0 2 10002", out_valid, out_sel, out_data);
      end
      force_sel = 4'd7; in_valid = 4'b1111;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++; $display("FAIL force_sel7_ready: got %b, expected 0000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL force_sel7_valid: got %b, expected 0", out_valid);
      end
      force_en = 1'b0;
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin
         errors++; $display("FAIL force_ptr_update: got %b, expected 1000", in_ready);
      end
      in_valid = 4'b0000;
   endtask

   task automatic test_fixed_priority();
      f_in_valid = 3'b110;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (f_in_ready !== 3'b010) begin
            errors++; $display("FAIL fp_ready[%0d]: got %b, expected 010", c, f_in_ready);
         end
         tick();
         checks++;
         if (f_out_valid !== 1'b1 || f_out_sel !== 2'd1 || f_out_data !== 8'h22) begin
            errors++; $display("FAIL fp_out[%0d]: got v=%b s=%0d d=%h, expected 1 1 22", c, f_out_valid, f_out_sel, f_out_data);
         end
      end
      f_force_en = 1'b1; f_force_sel = 4'd2;
      #1;
      checks++;
      if (f_in_ready !== 3'b100) begin
         errors++; $display("FAIL fp_force2_ready: got %b, expected 100", f_in_ready);
      end
      tick();
      checks++;
      if (f_out_sel !== 2'd2 || f_out_data !== 8'h33) begin
         errors++; $display("FAIL fp_force2_out: got s=%0d d=%h, expected 2 33", f_out_sel, f_out_data);
      end
      f_force_sel = 4'd3; f_in_valid = 3'b111;
      #1;
      checks++;
      if (f_in_ready !== 3'b000) begin
         errors++; $display("FAIL fp_force3_ready: got %b, expected 000", f_in_ready);
      end
      f_force_en = 1'b0;
      #1;
      checks++;
      if (f_in_ready !== 3'b001) begin
         errors++; $display("FAIL fp_lowest: got %b, expected 001", f_in_ready);
      end
      tick();
      checks++;
      if (f_out_sel !== 2'd0 || f_out_data !== 8'h11) begin
         errors++; $display("FAIL fp_lowest_out: got s=%0d d=%h, expected 0 11", f_out_sel, f_out_data);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_back_to_back();
      test_wrap();
      test_force();
      test_fixed_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
